icache_fetch_buffer: RTL and testbench

- Direct-mapped instruction cache between the instruction fetcher (upstream) and the memory controller (downstream).
- Serves 32-bit instruction fetches; on a miss, fills a whole line by issuing sequential word-read requests to the memory controller, which assembles each word from the 8-bit memory bus.
- Also absorbs fetcher flushes (clear on branch mispredict) without corrupting memory-controller transactions.

---
 rtl/icache_fetch_buffer.sv | 142 ++++++++++++++
 tb/tb_icache_fetch_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_buffer.sv
// Direct-mapped instruction cache: serves 32-bit fetches in 1 cycle on a hit and
// fills whole lines in word order from the memory controller on a miss.
module icache_fetch_buffer #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int WB       = OFFSET_BITS - 2;
  localparam int WORDS    = 1 << WB;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {S_IDLE, S_FILL} state_e;

  state_e                state_q, state_d;
  logic [WB-1:0]         cnt_q, cnt_d;
  logic                  flush_q, flush_d;
  logic [31:2]           req_q, req_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [31:0]           inst_out_q, inst_out_d;
  logic                  mc_req_q, mc_req_d;
  logic [31:0]           mc_addr_q, mc_addr_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES][WORDS];

  logic [TAG_BITS-1:0]   f_tag, r_tag;
  logic [INDEX_BITS-1:0] f_idx, r_idx;
  logic [WB-1:0]         f_word, r_word;
  logic                  hit, last, fill_we;
  logic                  unused_addr_lsb;

  assign f_tag   = fetch_addr[31:INDEX_BITS+OFFSET_BITS];
  assign f_idx   = fetch_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign f_word  = fetch_addr[OFFSET_BITS-1:2];
  assign r_tag   = req_q[31:INDEX_BITS+OFFSET_BITS];
  assign r_idx   = req_q[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign r_word  = req_q[OFFSET_BITS-1:2];
  assign unused_addr_lsb = ^fetch_addr[1:0];

  assign hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign last    = (cnt_q == {WB{1'b1}});
  assign fill_we = (state_q == S_FILL) && mc_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    req_d        = req_q;
    inst_valid_d = 1'b0;
    inst_out_d   = inst_out_q;
    mc_req_d     = mc_req_q;
    mc_addr_d    = mc_addr_q;
    case (state_q)
      S_IDLE: begin
        // A response cycle blocks acceptance so the fetcher can move on first.
        if (fetch_valid && !inst_valid_q && !clear_in) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_out_d   = data_q[f_idx][f_word];
          end else begin
            state_d   = S_FILL;
            req_d     = fetch_addr[31:2];
            cnt_d     = '0;
            flush_d   = 1'b0;
            mc_req_d  = 1'b1;
            mc_addr_d = {fetch_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
      end
      S_FILL: begin
        if (clear_in) flush_d = 1'b1;
        if (mc_done) begin
          cnt_d     = cnt_q + 1'b1;
          mc_addr_d = {req_q[31:OFFSET_BITS], cnt_d, 2'b00};
          if (last) begin
            state_d   = S_IDLE;
            mc_req_d  = 1'b0;
            mc_addr_d = '0;
            flush_d   = 1'b0;
            // The last word is still in flight to the array, so forward it.
            if (!flush_q && !clear_in) begin
              inst_valid_d = 1'b1;
              inst_out_d   = (r_word == cnt_q) ? mc_data : data_q[r_idx][r_word];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear_in) inst_valid_d = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      req_q        <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      mc_req_q     <= 1'b0;
      mc_addr_q    <= '0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      req_q        <= req_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      mc_req_q     <= mc_req_d;
      mc_addr_q    <= mc_addr_d;
      if (fill_we && last) valid_q[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_we) begin
      data_q[r_idx][cnt_q] <= mc_data;
      if (last) tag_q[r_idx] <= r_tag;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign mc_req     = mc_req_q;
  assign mc_addr    = mc_addr_q;
endmodule

// File: tb/tb_icache_fetch_buffer.sv
// Directed bench for icache_fetch_buffer: misses, hits, eviction, flush, stall, reset.
module tb_icache_fetch_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, fetch_valid, mc_done;
  logic [31:0] fetch_addr, mc_data;
  logic        inst_valid, mc_req;
  logic [31:0] inst_out, mc_addr;
  int          vectors = 0, miscompares = 0;

  icache_fetch_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .inst_valid(inst_valid), .inst_out(inst_out),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_valid = 1'b1; fetch_addr = a;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] d);
    mc_done = 1'b1; mc_data = d;
    tick();
    mc_done = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; fetch_valid = 1'b0;
    fetch_addr = '0; mc_done = 1'b0; mc_data = '0;
    repeat (2) tick();
    chk("rst_iv", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, mc_req}, 32'd0);
    chk("rst_addr", mc_addr, 32'h0);
    chk("rst_out", inst_out, 32'h0);
    rst_in = 1'b1;

    fetch(32'h0);
    chk("cold0_req", {31'd0, mc_req}, 32'd1);
    chk("cold0_iv", {31'd0, inst_valid}, 32'd0);
    rst_in = 1'b0; tick(); rst_in = 1'b1;
    chk("rstfill_req", {31'd0, mc_req}, 32'd0);

    // cold miss, requested word 1
    fetch(32'h0000_1004);
    chk("miss_req", {31'd0, mc_req}, 32'd1);
    chk("miss_a0", mc_addr, 32'h1000);
    serve(32'hA0); chk("miss_a1", mc_addr, 32'h1004);
    serve(32'hA1); chk("miss_a2", mc_addr, 32'h1008);
    serve(32'hA2); chk("miss_a3", mc_addr, 32'h100C);
    chk("miss_iv_early", {31'd0, inst_valid}, 32'd0);
    serve(32'hA3);
    chk("miss_iv", {31'd0, inst_valid}, 32'd1);
    chk("miss_out", inst_out, 32'hA1);
    chk("miss_req_dn", {31'd0, mc_req}, 32'd0);
    tick();
    chk("miss_pulse", {31'd0, inst_valid}, 32'd0);

    // hit with fetch held: second cycle ignored, third accepted
    fetch_valid = 1'b1; fetch_addr = 32'h0000_100C;
    tick();
    chk("hit_iv", {31'd0, inst_valid}, 32'd1);
    chk("hit_out", inst_out, 32'hA3);
    chk("hit_req", {31'd0, mc_req}, 32'd0);
    tick();
    chk("hit_gap", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("hit_again", {31'd0, inst_valid}, 32'd1);
    fetch_valid = 1'b0;
    tick();

    // conflict eviction, requested word 0 comes from the array
    fetch(32'h0000_1100);
    chk("evict_a0", mc_addr, 32'h1100);
    for (int i = 0; i < 4; i++) begin
      serve(32'hB0 + i);
      if (i < 3) chk("evict_seq", mc_addr, 32'h1100 + 4 * (i + 1));
    end
    chk("evict_out", inst_out, 32'hB0);
    tick();
    fetch(32'h0000_1004);
    chk("remiss_req", {31'd0, mc_req}, 32'd1);
    chk("remiss_a0", mc_addr, 32'h1000);
    serve(32'hA0); serve(32'hA1);

    // stall with spurious mc_done/clear that must be ignored
    rdy_in = 1'b0; mc_done = 1'b1; mc_data = 32'hDEAD; clear_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_addr", mc_addr, 32'h1008);
    end
    rdy_in = 1'b1; mc_done = 1'b0; clear_in = 1'b0;
    chk("stall_req", {31'd0, mc_req}, 32'd1);
    serve(32'hA2); chk("stall_a3", mc_addr, 32'h100C);
    serve(32'hA3);
    chk("stall_iv", {31'd0, inst_valid}, 32'd1);
    chk("stall_out", inst_out, 32'hA1);
    tick();
    fetch(32'h0000_1008);
    chk("stall_word", inst_out, 32'hA2);
    tick();

    // flush mid-fill
    fetch(32'h0000_2008);
    serve(32'hC0); serve(32'hC1);
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    chk("flush_addr", mc_addr, 32'h2008);
    serve(32'hC2); serve(32'hC3);
    chk("flush_iv", {31'd0, inst_valid}, 32'd0);
    chk("flush_req", {31'd0, mc_req}, 32'd0);
    tick();
    chk("flush_iv2", {31'd0, inst_valid}, 32'd0);
    clear_in = 1'b1; fetch(32'h0000_2008); clear_in = 1'b0;
    chk("clr_hit_iv", {31'd0, inst_valid}, 32'd0);
    fetch(32'h0000_2008);
    chk("flush_hit_iv", {31'd0, inst_valid}, 32'd1);
    chk("flush_hit_out", inst_out, 32'hC2);
    chk("flush_hit_req", {31'd0, mc_req}, 32'd0);
    tick();

    // clear coincident with last mc_done
    fetch(32'h0000_3010);
    serve(32'hD0); serve(32'hD1); serve(32'hD2);
    clear_in = 1'b1; serve(32'hD3); clear_in = 1'b0;
    chk("clrlast_iv", {31'd0, inst_valid}, 32'd0);
    chk("clrlast_req", {31'd0, mc_req}, 32'd0);
    tick();
    fetch(32'h0000_301C);
    chk("clrlast_hit", inst_out, 32'hD3);
    chk("clrlast_hiv", {31'd0, inst_valid}, 32'd1);
    tick();

    // requested word is the last one: forwarded from mc_data
    fetch(32'h0000_404C);
    serve(32'hE0); serve(32'hE1); serve(32'hE2); serve(32'hE3);
    chk("fwd_iv", {31'd0, inst_valid}, 32'd1);
    chk("fwd_out", inst_out, 32'hE3);
    tick();

    // reset mid-fill
    fetch(32'h0000_5050);
    serve(32'hF0);
    rst_in = 1'b0; tick(); rst_in = 1'b1;
    chk("rstmid_req", {31'd0, mc_req}, 32'd0);
    chk("rstmid_addr", mc_addr, 32'h0);
    fetch(32'h0000_5050);
    chk("rstmid_remiss", {31'd0, mc_req}, 32'd1);
    chk("rstmid_a0", mc_addr, 32'h5050);
    rst_in = 1'b0; tick(); rst_in = 1'b1;
    fetch(32'h0000_100C);
    chk("rst_inval", {31'd0, mc_req}, 32'd1);
    chk("rst_inval_iv", {31'd0, inst_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
